// File: rtl/if_id_register_if.sv
// Signal bundle between the fetch stage (master) and the IF/ID pipeline register (slave).
interface if_id_register_if;
  logic [31:0] PCplus;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Flush;
  logic        IRQ;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PCplus;
  logic        ID_Valid;
  logic        ID_IRQ;
  logic        StallErr;

  modport master (
    output PCplus, Instruction, Stall, Flush, IRQ,
    input  ID_Instruction, ID_PCplus, ID_Valid, ID_IRQ, StallErr
  );

  modport slave (
    input  PCplus, Instruction, Stall, Flush, IRQ,
    output ID_Instruction, ID_PCplus, ID_Valid, ID_IRQ, StallErr
  );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load, hold on stall, squash on flush, and inject
// pending user-mode interrupts into decode as a marked bubble.
module if_id_register #(
  parameter logic [31:0] RESET_PCPLUS = 32'h80000000,
  parameter logic [31:0] NOP_INSTR    = 32'h00000000,
  parameter int          STALL_LIMIT  = 8
) (
  input logic               clk,
  input logic               reset,
  if_id_register_if.slave   bus
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT + 1);

  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pcplus_q, pcplus_d;
  logic             valid_q, valid_d;
  logic             id_irq_q, id_irq_d;
  logic             stall_err_q, stall_err_d;
  logic             irq_pending_q, irq_pending_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic kernel_mode;
  logic inject;

  always_comb begin
    instr_d       = instr_q;
    pcplus_d      = pcplus_q;
    valid_d       = valid_q;
    id_irq_d      = id_irq_q;
    stall_err_d   = stall_err_q;
    irq_pending_d = irq_pending_q;
    stall_cnt_d   = '0;

    kernel_mode = bus.PCplus[31];
    inject      = (irq_pending_q | bus.IRQ) & ~kernel_mode & ~bus.Stall & ~bus.Flush;

    if (bus.Flush) begin
      instr_d  = NOP_INSTR;
      pcplus_d = bus.PCplus;
      valid_d  = 1'b0;
      id_irq_d = 1'b0;
    end else if (bus.Stall) begin
      instr_d  = instr_q;
    end else if (inject) begin
      instr_d  = NOP_INSTR;
      pcplus_d = bus.PCplus;
      valid_d  = 1'b0;
      id_irq_d = 1'b1;
    end else begin
      instr_d  = bus.Instruction;
      pcplus_d = bus.PCplus;
      valid_d  = 1'b1;
      id_irq_d = 1'b0;
    end

    // A request seen in user mode is remembered even across stalls and flushes.
    if (inject) begin
      irq_pending_d = 1'b0;
    end else begin
      irq_pending_d = irq_pending_q | (bus.IRQ & ~kernel_mode);
    end

    if (bus.Stall && !bus.Flush) begin
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    end
    stall_err_d = stall_err_q | (stall_cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q       <= NOP_INSTR;
      pcplus_q      <= RESET_PCPLUS;
      valid_q       <= 1'b0;
      id_irq_q      <= 1'b0;
      stall_err_q   <= 1'b0;
      irq_pending_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      instr_q       <= instr_d;
      pcplus_q      <= pcplus_d;
      valid_q       <= valid_d;
      id_irq_q      <= id_irq_d;
      stall_err_q   <= stall_err_d;
      irq_pending_q <= irq_pending_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.ID_Instruction = instr_q;
  assign bus.ID_PCplus      = pcplus_q;
  assign bus.ID_Valid       = valid_q;
  assign bus.ID_IRQ         = id_irq_q;
  assign bus.StallErr       = stall_err_q;

endmodule

// File: tb/tb_if_id_register.sv
// Scoreboard bench for if_id_register: directed vectors push hand-computed
// expectations, a monitor pops and compares one entry after each rising edge.
module tb_if_id_register;

  typedef struct {
    int          id;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        irq;
    logic        err;
  } exp_t;

  localparam logic [31:0] RP = 32'h80000000;

  logic clk;
  logic reset;
  if_id_register_if bus();

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   vecId      = 0;

  if_id_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rstn, input logic stall, input logic flush,
                               input logic irq, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] eInstr, input logic [31:0] ePc,
                               input logic eValid, input logic eIrq, input logic eErr);
    exp_t e;
    @(negedge clk);
    reset           = rstn;
    bus.Stall       = stall;
    bus.Flush       = flush;
    bus.IRQ         = irq;
    bus.PCplus      = pc;
    bus.Instruction = instr;
    vecId++;
    e.id = vecId; e.instr = eInstr; e.pc = ePc; e.valid = eValid; e.irq = eIrq; e.err = eErr;
    sbQ.push_back(e);
  endtask

  task automatic cmp(input int id, input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL vec%0d %s: got %h want %h", id, name, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.id, "ID_Instruction", bus.ID_Instruction, e.instr);
    cmp(e.id, "ID_PCplus", bus.ID_PCplus, e.pc);
    cmp(e.id, "ID_Valid", {31'b0, bus.ID_Valid}, {31'b0, e.valid});
    cmp(e.id, "ID_IRQ", {31'b0, bus.ID_IRQ}, {31'b0, e.irq});
    cmp(e.id, "StallErr", {31'b0, bus.StallErr}, {31'b0, e.err});
  endtask

  // Monitor: every output update after a rising edge is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.IRQ = 1'b0;
    bus.PCplus = 32'h0; bus.Instruction = 32'h0;

    // reset values, then first load
    applyStimulus(0,0,0,0, 32'h4, 32'h20080005,  32'h0, RP, 0,0,0);
    applyStimulus(0,0,0,0, 32'h4, 32'h20080005,  32'h0, RP, 0,0,0);
    applyStimulus(1,0,0,0, 32'h4, 32'h20080005,  32'h20080005, 32'h4, 1,0,0);
    applyStimulus(1,0,0,0, 32'h8, 32'h01095020,  32'h01095020, 32'h8, 1,0,0);
    // three-cycle stall with changing inputs
    applyStimulus(1,1,0,0, 32'hC,  32'h11111111, 32'h01095020, 32'h8, 1,0,0);
    applyStimulus(1,1,0,0, 32'h10, 32'h22222222, 32'h01095020, 32'h8, 1,0,0);
    applyStimulus(1,1,0,0, 32'h14, 32'h33333333, 32'h01095020, 32'h8, 1,0,0);
    applyStimulus(1,0,0,0, 32'hC,  32'hAC0A0004, 32'hAC0A0004, 32'hC, 1,0,0);
    // flush wins over stall
    applyStimulus(1,1,1,0, 32'h40, 32'h8C090000, 32'h0, 32'h40, 0,0,0);
    applyStimulus(1,0,0,0, 32'h44, 32'h21290001, 32'h21290001, 32'h44, 1,0,0);
    // IRQ pulse during stall, injected once stall drops
    applyStimulus(1,1,0,1, 32'h10, 32'h12345678, 32'h21290001, 32'h44, 1,0,0);
    applyStimulus(1,1,0,0, 32'h10, 32'h12345678, 32'h21290001, 32'h44, 1,0,0);
    applyStimulus(1,0,0,0, 32'h10, 32'h8D2A0000, 32'h0, 32'h10, 0,1,0);
    applyStimulus(1,0,0,0, 32'h14, 32'h01495820, 32'h01495820, 32'h14, 1,0,0);
    // IRQ during flush is queued; injected bubble holds through a stall
    applyStimulus(1,0,1,1, 32'h18, 32'hDEADBEEF, 32'h0, 32'h18, 0,0,0);
    applyStimulus(1,0,0,0, 32'h1C, 32'hAAAA0000, 32'h0, 32'h1C, 0,1,0);
    applyStimulus(1,1,0,0, 32'h20, 32'hBBBB0000, 32'h0, 32'h1C, 0,1,0);
    applyStimulus(1,0,0,0, 32'h20, 32'h3C010001, 32'h3C010001, 32'h20, 1,0,0);
    // IRQ in kernel mode is ignored and not queued
    applyStimulus(1,0,0,1, 32'h80000008, 32'h40826000, 32'h40826000, 32'h80000008, 1,0,0);
    applyStimulus(1,0,0,1, 32'h8000000C, 32'h42000018, 32'h42000018, 32'h8000000C, 1,0,0);
    applyStimulus(1,0,0,0, 32'h24, 32'h24020001, 32'h24020001, 32'h24, 1,0,0);
    applyStimulus(1,0,0,0, 32'h28, 32'h24030002, 32'h24030002, 32'h28, 1,0,0);
    // nine consecutive stalls trip the sticky error on the ninth edge
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1,1,0,0, 32'h100 + 4*i, 32'h55550000 + i, 32'h24030002, 32'h28, 1,0, (i == 8));
    end
    applyStimulus(1,0,0,0, 32'h2C, 32'h24040003, 32'h24040003, 32'h2C, 1,0,1);
    applyStimulus(1,0,0,0, 32'h30, 32'h24050004, 32'h24050004, 32'h30, 1,0,1);
    applyStimulus(0,0,0,0, 32'h34, 32'h00851020, 32'h0, RP, 0,0,0);
    applyStimulus(1,0,0,0, 32'h34, 32'h00851020, 32'h00851020, 32'h34, 1,0,0);
    // reset drops a pending interrupt
    applyStimulus(1,1,0,1, 32'h38, 32'h00000000, 32'h00851020, 32'h34, 1,0,0);
    applyStimulus(0,0,0,0, 32'h3C, 32'h00A62020, 32'h0, RP, 0,0,0);
    applyStimulus(1,0,0,0, 32'h3C, 32'h00A62020, 32'h00A62020, 32'h3C, 1,0,0);

    repeat (3) @(negedge clk);
    if (sbQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending want 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
